// File: rtl/noc_pkg.sv
// Shared definitions for the merge arbiter slice.
//   PKT_W              packet width (address [8:5], payload [4:0])
//   ADDR_MSB/ADDR_LSB  destination address field bounds
//   state_e            merge FSM states
package noc_pkg;
  localparam int PKT_W    = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_DATA = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter for the merge block.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_req[1:0]   requests (bit n = port n valid)
//   i_en         an input transfer happened; advance the pointer
//   o_gnt[1:0]   one-hot grant (zero when nothing requests)
//   o_idx        winning port index
// Macro MERGE_ARBITER_RR_EN: round-robin pointer; otherwise fixed
// priority with port 0 winning ties and no pointer register.
module rr_arb2
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

`ifdef MERGE_ARBITER_RR_EN
  // Points at the port preferred on a tie; after a grant it moves to the loser.
  logic r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ptr <= 1'b0;
    else if (i_en) r_ptr <= ~o_idx;
  end

  // Port 1 wins when it is alone or when it holds the tie preference.
  assign o_idx = i_req[1] & (~i_req[0] | r_ptr);
`else
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_en};

  assign o_idx = i_req[1] & ~i_req[0];
`endif

  assign o_gnt = {o_idx & i_req[1], ~o_idx & i_req[0]};

endmodule

// File: rtl/merge_arbiter.sv
// Merges two packet streams into one, emitting a source-select token
// ahead of every packet. Single-entry: accept -> token -> packet.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in0_valid/in0_ready/in0_data   upstream port 0
//   in1_valid/in1_ready/in1_data   upstream port 1
//   sel_valid/sel_ready/sel_data   source token (0 = in0, 1 = in1)
//   out_valid/out_ready/out_data   merged packet, unmodified
// Macro MERGE_ARBITER_RR_EN: round-robin tie breaking (default: port 0).
module merge_arbiter
  import noc_pkg::*;
#(
  parameter int W = PKT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in0_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [W-1:0] in1_data,
  output logic         sel_valid,
  input  logic         sel_ready,
  output logic         sel_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_e         r_state, w_nxt;
  logic [W-1:0]   r_data;
  logic           r_src;
  logic [1:0]     w_gnt;
  logic           w_idx;
  logic           w_acc;

  // An input transfer: idle, out of reset, and someone is offering.
  assign w_acc = rst_n & (r_state == ST_IDLE) & (in0_valid | in1_valid);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({in1_valid, in0_valid}),
    .i_en  (w_acc),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_src   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_data <= w_idx ? in1_data : in0_data;
        r_src  <= w_idx;
      end
    end
  end

  // Outputs are decoded from state so that every output is zero outside
  // the state that owns it (and zero throughout reset).
  always_comb begin
    w_nxt     = r_state;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    sel_valid = 1'b0;
    sel_data  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (r_state)
      ST_IDLE: begin
        // Ready is gated by rst_n so it reads zero while reset is held.
        in0_ready = rst_n & w_gnt[0];
        in1_ready = rst_n & w_gnt[1];
        if (w_acc) w_nxt = ST_SEL;
      end
      ST_SEL: begin
        sel_valid = 1'b1;
        sel_data  = r_src;
        if (sel_ready) w_nxt = ST_DATA;
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out_data  = r_data;
        if (out_ready) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

endmodule
